uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Arbiter that shares the single SoC UART transmitter between NUM_REQ byte-stream requesters, such as the core console path and the JTAG debug print path. Arbitration is packet-granular and round-robin. A grant is held until the requester's last byte is accepted, so lines from different sources never interleave on uart_tx. A stall timeout releases a grant held by a requester that stops mid-packet. Sits inside top, between the requesters and the UART TX byte interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 1024, cycles of granted-requester inactivity before forced release; 0 disables the timeout
CNT_W, 11, timeout counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid_i  input  NUM_REQ  per-requester byte valid
req_data_i  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last_i  input  NUM_REQ  byte is the last of its packet
req_ready_o  output  NUM_REQ  per-requester accept
tx_valid_o  output  1  byte valid to UART TX
tx_data_o  output  DATA_W  byte to UART TX
tx_ready_i  input  1  UART TX accepts byte
grant_o  output  NUM_REQ  one-hot current owner; all zero when idle
busy_o  output  1  high while in LOCKED
timeout_o  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant=0, timeout counter=0, timeout_o=0.
  - All outputs are 0 in the cycle after reset. Reset asserted mid-packet drops the grant immediately; no partial byte is held.
- Handshake: a transfer occurs when tx_valid_o and tx_ready_i are both 1 at a clk edge. Requesters must hold valid/data/last stable until ready.
- IDLE:
  - tx_valid_o=0, req_ready_o=0.
  - If any req_valid_i bit is set, select the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - The selection is registered into grant; next state is LOCKED.
  - Arbitration latency: 1 cycle from the first valid to tx_valid_o.
- LOCKED with owner g:
  - Combinational pass-through: tx_valid_o=req_valid_i[g], tx_data_o=data[g], req_ready_o[g]=tx_ready_i; all other ready bits are 0.
  - Other requesters' valids are ignored regardless of value.
  - A transfer with req_last_i[g]=1 sets next state to IDLE, grant=0, and rr_ptr=(g+1) mod NUM_REQ.
  - This gives one bubble cycle between packets. Max throughput is one byte/cycle within a packet.
  - tx_data_o=0 whenever tx_valid_o=0.
- Timeout (TIMEOUT>0, LOCKED only):
  - The counter increments on each cycle where req_valid_i[g]=0.
  - It clears on any cycle where req_valid_i[g]=1. This includes cycles stalled by tx_ready_i=0, so UART backpressure never triggers release.
  - When the counter equals TIMEOUT-1 and req_valid_i[g]=0: go to IDLE, advance rr_ptr as for last, and pulse timeout_o for exactly 1 cycle (registered).
  - Because release only happens while the owner's valid is low, tx_valid_o never drops with a byte pending.
  - The counter clears on entry to LOCKED.
- Simultaneous events:
  - last transfer and timeout condition cannot coincide, since valid is high on a transfer.
  - A new request arriving in the bubble cycle after release is arbitrated normally in IDLE, with the updated rr_ptr.
- Widths: rr_ptr is clog2(NUM_REQ) bits and wraps modulo NUM_REQ, not at the power of two. The counter saturates and never wraps.
- grant_o is one-hot or zero at all times. busy_o = (state==LOCKED).

Test Plan:
1. Single packet, no backpressure:
   - Stimulus: req0 sends 0x41, 0x42, 0x0A (last on 0x0A), tx_ready_i=1.
   - Required: tx_valid_o rises 1 cycle after req_valid_i[0]; bytes appear on 3 consecutive cycles; grant_o=01 then 00; rr_ptr=1.
2. Contention and round-robin:
   - Stimulus: req0 and req1 each hold a 2-byte packet from cycle 0, rr_ptr=0.
   - Required: req0's packet, 1 bubble, then req1's packet. A repeat with both requesting again serves req0 first (rr_ptr wrapped to 0).
3. Lock hold:
   - Stimulus: req1 asserts valid mid-way through req0's 4-byte packet.
   - Required: req_ready_o[1] stays 0 and no req1 byte is interleaved. req1 is granted in the cycle after req0's last byte plus arbitration.
4. Backpressure:
   - Stimulus: tx_ready_i=0 for 2000 cycles with req0 valid, TIMEOUT=1024.
   - Required: no timeout_o; tx_data_o stable; the byte transfers when ready returns.
5. Timeout:
   - Stimulus: req0 sends 1 byte without last, then drops valid.
   - Required: timeout_o pulses exactly 1024 cycles after valid drops; grant_o=00; a waiting req1 is granted next.
6. Reset mid-packet:
   - Stimulus: rst=1 for 1 cycle after byte 2 of 4.
   - Required: all outputs 0 the next cycle, state IDLE, rr_ptr=0; a re-presented request is granted with 1-cycle latency.

Source files
------------

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one UART transmitter byte interface between NUM_REQ byte-stream
// requesters (e.g. the core console path and the JTAG debug print path).
// Arbitration is round-robin and packet-granular. Once a requester is
// granted, it keeps the transmitter until its last byte is accepted, so
// lines from different sources never interleave. If a granted requester
// goes quiet mid-packet for TIMEOUT cycles, its grant is forcibly released.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last_i   per-requester "this byte ends the packet"
//   req_ready_o  per-requester accept (only the owner can see ready)
//   tx_valid_o   byte valid towards the UART TX
//   tx_data_o    byte towards the UART TX (zero whenever tx_valid_o is low)
//   tx_ready_i   UART TX accepts the byte
//   grant_o      one-hot current owner, all zero while idle
//   busy_o       high while a requester owns the transmitter
//   timeout_o    one-cycle pulse when a stalled owner is forcibly released
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        tx_valid_o,
    output logic [DATA_W-1:0]           tx_data_o,
    input  logic                        tx_ready_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // One extra bit so that pointer sums can be wrapped modulo NUM_REQ,
    // which need not be a power of two.
    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   idle_cnt;
    logic               timeout_q;

    logic [PTR_W-1:0]   owner;
    logic               owner_valid;
    logic               owner_last;
    logic [PTR_W:0]     ptr_inc;
    logic [PTR_W-1:0]   next_ptr;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W:0]     scan_idx;
    logic               found;

    // Decode the one-hot grant into the owner's index and gather the owner's
    // valid/last. With grant all zero (IDLE) the valid/last come out zero.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner = PTR_W'(i);
            end
        end
        owner_valid = |(req_valid_i & grant);
        owner_last  = |(req_last_i & grant);
    end

    // Pointer value used after any release: the requester after the owner.
    always_comb begin
        ptr_inc = {1'b0, owner} + (PTR_W + 1)'(1);
        if (ptr_inc == NUM_REQ_EXT) begin
            ptr_inc = '0;
        end
        next_ptr = ptr_inc[PTR_W-1:0];
    end

    // Round-robin pick: the first valid requester found scanning upward from
    // rr_ptr, wrapping at NUM_REQ rather than at the next power of two.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_idx >= NUM_REQ_EXT) begin
                scan_idx = scan_idx - NUM_REQ_EXT;
            end
            if (!found && req_valid_i[scan_idx[PTR_W-1:0]]) begin
                pick[scan_idx[PTR_W-1:0]] = 1'b1;
                found                     = 1'b1;
            end
        end
    end

    // Data path is a pure pass-through from the owner. Because grant is zero
    // in IDLE, every output here is naturally zero there, and the AND-OR mux
    // keeps tx_data_o at zero whenever the owner's valid is low.
    always_comb begin
        tx_valid_o = owner_valid;
        tx_data_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req_valid_i[i]) begin
                tx_data_o = tx_data_o | req_data_i[i*DATA_W +: DATA_W];
            end
        end
        req_ready_o = grant & {NUM_REQ{tx_ready_i}};
    end

    // Arbitration FSM. The inactivity counter only advances while the owner
    // has nothing to offer; a stalled-but-valid owner (UART backpressure)
    // keeps clearing it, so backpressure alone can never force a release.
    // Release on timeout happens only while the owner's valid is low, so no
    // offered byte is ever withdrawn from tx_valid_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        state    <= LOCKED;
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (owner_valid) begin
                        idle_cnt <= '0;
                        if (tx_ready_i && owner_last) begin
                            state  <= IDLE;
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                        end
                    end else if ((TIMEOUT > 0) && (idle_cnt == CNT_LAST)) begin
                        state     <= IDLE;
                        grant     <= '0;
                        rr_ptr    <= next_ptr;
                        idle_cnt  <= '0;
                        timeout_q <= 1'b1;
                    end else if (idle_cnt != CNT_MAX) begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign grant_o   = grant;
    assign busy_o    = (state == LOCKED);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Self-checking bench for uart_tx_arb with two requesters and TIMEOUT=1024.
// First part: a cycle-by-cycle table of inputs and expected outputs covering
// reset, single packets, round-robin contention, backpressure and the
// tx_data zeroing rule. Second part: queue-driven requesters with a
// scoreboard of expected {grant, byte} transfers for lock hold,
// long backpressure, stall timeout and reset in the middle of a packet.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;

    uart_tx_arb #(
        .NUM_REQ (2),
        .DATA_W  (8),
        .TIMEOUT (1024),
        .CNT_W   (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running cycle index, stable between rising edges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Compares one observed value against its required value
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reports an expired wait or missing event as a failed comparison
    task automatic report_missing(input string name, input int waited);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: expected event missing after %0d cycles", name, waited);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] last;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_ready;
        logic [1:0] exp_grant;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] l, input logic rd, input logic ev, input logic [7:0] ed,
                           input logic [1:0] er, input logic [1:0] eg, input logic eb);
        vec_t t;
        t.rst       = r;
        t.valid     = v;
        t.d0        = a;
        t.d1        = b;
        t.last      = l;
        t.ready     = rd;
        t.exp_valid = ev;
        t.exp_data  = ed;
        t.exp_ready = er;
        t.exp_grant = eg;
        t.exp_busy  = eb;
        vecs.push_back(t);
    endtask

    // ---------------- queue-driven requesters and scoreboard ----------------
    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    bit         en0 = 1'b0;
    bit         en1 = 1'b0;
    bit         sb_en = 1'b0;
    logic [9:0] sb[$];
    logic [9:0] sb_item;
    int         xfer_cyc[$];
    int         to_cyc[$];
    logic [1:0] to_grant;

    // Presents the head of each enabled requester queue
    task automatic drive();
        logic [8:0] h;
        req_valid_i = 2'b00;
        req_data_i  = 16'h0000;
        req_last_i  = 2'b00;
        if (en0 && rq0.size() > 0) begin
            h              = rq0[0];
            req_valid_i[0] = 1'b1;
            req_data_i[7:0] = h[7:0];
            req_last_i[0]  = h[8];
        end
        if (en1 && rq1.size() > 0) begin
            h               = rq1[0];
            req_valid_i[1]  = 1'b1;
            req_data_i[15:8] = h[7:0];
            req_last_i[1]   = h[8];
        end
    endtask

    // Advances one cycle: notes accepted bytes, pops them, presents next
    task automatic apply_stimulus();
        logic [1:0] acc;
        @(negedge clk);
        acc = rst ? 2'b00 : (req_valid_i & req_ready_o);
        @(posedge clk);
        #1;
        if (acc[0]) void'(rq0.pop_front());
        if (acc[1]) void'(rq1.pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset();
        en0 = 1'b0;
        en1 = 1'b0;
        rq0.delete();
        rq1.delete();
        tx_ready_i = 1'b1;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int n;
        n = 0;
        while ((en0 && rq0.size() != 0) || (en1 && rq1.size() != 0) || grant_o != 2'b00 || sb.size() != 0) begin
            if (n >= bound) begin
                report_missing(name, n);
                return;
            end
            apply_stimulus();
            n++;
        end
    endtask

    // Scoreboard monitor: every handshake must match the next expected
    // {grant, byte}; timeout pulses are time-stamped.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (tx_valid_o && tx_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: actual grant %b byte 0x%0h, required no transfer", grant_o, tx_data_o);
                end else begin
                    sb_item = sb.pop_front();
                    check_output("sb_byte", 32'({grant_o, tx_data_o}), 32'(sb_item));
                    xfer_cyc.push_back(cyc);
                end
            end
            if (timeout_o) begin
                to_cyc.push_back(cyc);
                to_grant = grant_o;
            end
        end
    end

    // Hard stop so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    int base;
    int drop;
    int to_before;
    int unstable;

    initial begin
        rst         = 1'b1;
        req_valid_i = 2'b00;
        req_data_i  = 16'h0000;
        req_last_i  = 2'b00;
        tx_ready_i  = 1'b1;

        //      rst valid  d0     d1     last   rdy  ev   ed     er     eg     busy
        add_vec(1, 2'b00, 8'h00, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b01, 8'h41, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b01, 8'h41, 8'h00, 2'b00, 1,   1,   8'h41, 2'b01, 2'b01, 1);
        add_vec(0, 2'b01, 8'h42, 8'h00, 2'b00, 1,   1,   8'h42, 2'b01, 2'b01, 1);
        add_vec(0, 2'b01, 8'h0A, 8'h00, 2'b01, 1,   1,   8'h0A, 2'b01, 2'b01, 1);
        add_vec(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(1, 2'b00, 8'h00, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1,   1,   8'hA0, 2'b01, 2'b01, 1);
        add_vec(0, 2'b11, 8'hA1, 8'hB0, 2'b01, 1,   1,   8'hA1, 2'b01, 2'b01, 1);
        add_vec(0, 2'b10, 8'h00, 8'hB0, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b10, 8'h00, 8'hB0, 2'b00, 1,   1,   8'hB0, 2'b10, 2'b10, 1);
        add_vec(0, 2'b10, 8'h00, 8'hB1, 2'b10, 1,   1,   8'hB1, 2'b10, 2'b10, 1);
        add_vec(0, 2'b11, 8'hC0, 8'hD0, 2'b11, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b11, 8'hC0, 8'hD0, 2'b11, 1,   1,   8'hC0, 2'b01, 2'b01, 1);
        add_vec(0, 2'b10, 8'h00, 8'hD0, 2'b10, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b10, 8'h00, 8'hD0, 2'b10, 1,   1,   8'hD0, 2'b10, 2'b10, 1);
        add_vec(0, 2'b01, 8'hE0, 8'h00, 2'b01, 0,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b01, 8'hE0, 8'h00, 2'b01, 0,   1,   8'hE0, 2'b00, 2'b01, 1);
        add_vec(0, 2'b01, 8'hE0, 8'h00, 2'b01, 1,   1,   8'hE0, 2'b01, 2'b01, 1);
        add_vec(0, 2'b01, 8'hF0, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);
        add_vec(0, 2'b01, 8'hF0, 8'h00, 2'b00, 1,   1,   8'hF0, 2'b01, 2'b01, 1);
        add_vec(0, 2'b00, 8'hF5, 8'h00, 2'b00, 1,   0,   8'h00, 2'b01, 2'b01, 1);
        add_vec(1, 2'b00, 8'hF5, 8'h00, 2'b00, 1,   0,   8'h00, 2'b01, 2'b01, 1);
        add_vec(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,   0,   8'h00, 2'b00, 2'b00, 0);

        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            rst         = vecs[k].rst;
            req_valid_i = vecs[k].valid;
            req_data_i  = {vecs[k].d1, vecs[k].d0};
            req_last_i  = vecs[k].last;
            tx_ready_i  = vecs[k].ready;
            @(negedge clk);
            check_output($sformatf("vec%0d", k),
                         32'({tx_valid_o, tx_data_o, req_ready_o, grant_o, busy_o, timeout_o}),
                         32'({vecs[k].exp_valid, vecs[k].exp_data, vecs[k].exp_ready,
                              vecs[k].exp_grant, vecs[k].exp_busy, 1'b0}));
        end

        sb_en = 1'b1;

        // Lock hold: req1 shows up in the middle of req0's 4-byte packet
        do_reset();
        rq0.push_back(9'h010); rq0.push_back(9'h011); rq0.push_back(9'h012); rq0.push_back(9'h113);
        rq1.push_back(9'h020); rq1.push_back(9'h121);
        sb.push_back({2'b01, 8'h10}); sb.push_back({2'b01, 8'h11});
        sb.push_back({2'b01, 8'h12}); sb.push_back({2'b01, 8'h13});
        sb.push_back({2'b10, 8'h20}); sb.push_back({2'b10, 8'h21});
        base = xfer_cyc.size();
        en0 = 1'b1;
        drive();
        n = 0;
        while (rq0.size() > 2 && n < 20) begin
            apply_stimulus();
            n++;
        end
        en1 = 1'b1;
        drive();
        #1;
        check_output("lock_ready1", 32'(req_ready_o), 32'(2'b01));
        check_output("lock_grant", 32'(grant_o), 32'(2'b01));
        run_until_idle("lock_hold", 50);
        if (xfer_cyc.size() >= base + 6) begin
            check_output("lock_req0_back_to_back", 32'(xfer_cyc[base+3] - xfer_cyc[base]), 32'd3);
            check_output("lock_req1_gap", 32'(xfer_cyc[base+4] - xfer_cyc[base+3]), 32'd2);
        end else begin
            report_missing("lock_transfers", 50);
        end

        // Long backpressure must not trigger a release
        do_reset();
        tx_ready_i = 1'b0;
        rq0.push_back(9'h155);
        sb.push_back({2'b01, 8'h55});
        en0 = 1'b1;
        drive();
        to_before = to_cyc.size();
        unstable  = 0;
        for (int k = 0; k < 2000; k++) begin
            apply_stimulus();
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h55 || grant_o !== 2'b01) unstable++;
        end
        check_output("bp_stable_cycles", 32'(unstable), 32'd0);
        check_output("bp_no_timeout", 32'(to_cyc.size() - to_before), 32'd0);
        check_output("bp_byte_held", 32'(sb.size()), 32'd1);
        tx_ready_i = 1'b1;
        run_until_idle("backpressure", 10);

        // Stall timeout: req0 sends one byte without last and goes quiet
        do_reset();
        rq0.push_back(9'h066);
        sb.push_back({2'b01, 8'h66});
        en0 = 1'b1;
        drive();
        n = 0;
        while (rq0.size() != 0 && n < 10) begin
            apply_stimulus();
            n++;
        end
        drop = cyc;
        check_output("to_lock_held", 32'({busy_o, tx_valid_o}), 32'(2'b10));
        rq1.push_back(9'h177);
        sb.push_back({2'b10, 8'h77});
        en1 = 1'b1;
        drive();
        to_before = to_cyc.size();
        n = 0;
        while (to_cyc.size() == to_before && n < 1100) begin
            apply_stimulus();
            n++;
        end
        if (to_cyc.size() == to_before) begin
            report_missing("to_pulse", n);
        end else begin
            check_output("to_latency", 32'(to_cyc[to_before] - drop), 32'd1024);
            check_output("to_grant_released", 32'(to_grant), 32'(2'b00));
            check_output("to_pulse_width", 32'(timeout_o), 32'd0);
            check_output("to_next_grant", 32'(grant_o), 32'(2'b10));
            run_until_idle("timeout", 10);
            if (xfer_cyc.size() > 0)
                check_output("to_req1_latency", 32'(xfer_cyc[xfer_cyc.size()-1] - to_cyc[to_before]), 32'd1);
        end

        // Reset in the middle of a 4-byte packet
        do_reset();
        rq0.push_back(9'h030); rq0.push_back(9'h031); rq0.push_back(9'h032); rq0.push_back(9'h133);
        sb.push_back({2'b01, 8'h30}); sb.push_back({2'b01, 8'h31});
        sb.push_back({2'b01, 8'h32}); sb.push_back({2'b01, 8'h33});
        en0 = 1'b1;
        drive();
        n = 0;
        while (rq0.size() > 2 && n < 20) begin
            apply_stimulus();
            n++;
        end
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        check_output("rst_outputs",
                     32'({tx_valid_o, tx_data_o, req_ready_o, grant_o, busy_o, timeout_o}), 32'd0);
        apply_stimulus();
        check_output("rst_regrant", 32'({grant_o, tx_valid_o, tx_data_o}), 32'({2'b01, 1'b1, 8'h32}));
        run_until_idle("reset_mid", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
